// File: rtl/logic_gate_pkg.sv
// Shared definitions for the logic_gate pipeline: operation codes and op width.
package logic_gate_pkg;

    localparam int unsigned OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_XOR  = 3'd2,
        OP_NAND = 3'd3,
        OP_NOR  = 3'd4,
        OP_XNOR = 3'd5,
        OP_ANDN = 3'd6,
        OP_PASS = 3'd7
    } op_e;

endpackage

// File: rtl/logic_gate_core.sv
// Combinational WIDTH-bit logic function f(op,a,b) with zero / all-ones detect.
module logic_gate_core
    import logic_gate_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    output logic             zero,
    output logic             ones
);

    always_comb begin
        y = '0;
        case (op_e'(op))
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_NAND: y = ~(a & b);
            OP_NOR:  y = ~(a | b);
            OP_XNOR: y = ~(a ^ b);
            OP_ANDN: y = a & ~b;
            OP_PASS: y = a;
            default: y = '0;
        endcase
    end

    assign zero = (y == '0);
    assign ones = (y == '1);

endmodule

// File: rtl/logic_gate_pipe.sv
// Two-stage valid/ready pipeline around logic_gate_core with result flags
// and a saturating count of completed output handshakes.
module logic_gate_pipe
    import logic_gate_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OP_W-1:0]  op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             zero,
    output logic             ones,
    output logic [CNT_W-1:0] op_count
);

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d;
    logic [WIDTH-1:0] s1_b_q, s1_b_d;
    logic [OP_W-1:0]  s1_op_q, s1_op_d;

    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             zero_q, zero_d;
    logic             ones_q, ones_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             s1_adv, s2_adv;
    logic [WIDTH-1:0] f_y;
    logic             f_zero, f_ones;

    logic_gate_core #(.WIDTH(WIDTH)) u_core (
        .op   (s1_op_q),
        .a    (s1_a_q),
        .b    (s1_b_q),
        .y    (f_y),
        .zero (f_zero),
        .ones (f_ones)
    );

    assign s2_adv   = !s2_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_ready = s1_adv;

    // Data registers load only on real beats so idle X operands never propagate.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_op_d    = s1_op_q;
        s2_valid_d = s2_valid_q;
        y_d        = y_q;
        zero_d     = zero_q;
        ones_d     = ones_q;
        count_d    = count_q;

        if (s1_adv) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_a_d  = a;
                s1_b_d  = b;
                s1_op_d = op;
            end
        end

        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                y_d    = f_y;
                zero_d = f_zero;
                ones_d = f_ones;
            end
        end

        if (s2_valid_q && out_ready && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_op_q    <= '0;
            s2_valid_q <= 1'b0;
            y_q        <= '0;
            zero_q     <= 1'b0;
            ones_q     <= 1'b0;
            count_q    <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s1_op_q    <= s1_op_d;
            s2_valid_q <= s2_valid_d;
            y_q        <= y_d;
            zero_q     <= zero_d;
            ones_q     <= ones_d;
            count_q    <= count_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign y         = y_q;
    assign zero      = zero_q;
    assign ones      = ones_q;
    assign op_count  = count_q;

endmodule

// File: tb/tb_logic_gate_pipe.sv
// Self-checking bench for logic_gate_pipe: truth-table reference model with a
// result queue, plus a CNT_W=3 instance for counter saturation.
module tb_logic_gate_pipe;

    typedef struct {
        logic [7:0] y;
        logic       zero;
        logic       ones;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic [2:0] op = '0;

    logic        in_ready, out_valid, zero, ones;
    logic [7:0]  y;
    logic [15:0] op_count;

    logic       in_ready_s, out_valid_s, zero_s, ones_s;
    logic [7:0] y_s;
    logic [2:0] op_count_s;

    int total = 0;
    int bad   = 0;
    exp_t exp_q[$];

    // Per-op truth table indexed by {a_bit, b_bit}
    logic [3:0] tt_tab [8] = '{4'b1000, 4'b1110, 4'b0110, 4'b0111,
                               4'b0001, 4'b1001, 4'b0100, 4'b1100};

    always #5 clk = ~clk;

    logic_gate_pipe #(.WIDTH(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .zero(zero), .ones(ones), .op_count(op_count)
    );

    logic_gate_pipe #(.WIDTH(8), .CNT_W(3)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
        .a(a), .b(b), .op(op), .out_valid(out_valid_s), .out_ready(out_ready),
        .y(y_s), .zero(zero_s), .ones(ones_s), .op_count(op_count_s)
    );

    function automatic exp_t model(input logic [2:0] mop, input logic [7:0] ma, input logic [7:0] mb);
        exp_t e;
        logic [3:0] tt;
        tt = tt_tab[mop];
        for (int i = 0; i < 8; i++) e.y[i] = tt[{ma[i], mb[i]}];
        e.zero = (e.y == 8'h00);
        e.ones = (e.y == 8'hFF);
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (out_valid !== 1'b0 || y !== 8'h00 || zero !== 1'b0 || ones !== 1'b0 || op_count !== 16'd0) begin
            bad++;
            $display("FAIL reset_state: out_valid=%b y=%h zero=%b ones=%b op_count=%0d, required 0 0 0 0 0",
                     out_valid, y, zero, ones, op_count);
        end
        rst = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_in_ready: in_ready=%b required 1", in_ready);
        end
        exp_q.delete();
    endtask

    task automatic test_all_ops();
        logic [7:0] exp_y [8] = '{8'hC0, 8'hFC, 8'h3C, 8'h3F, 8'h03, 8'hC3, 8'h30, 8'hF0};
        reset_dut();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            a = 8'hF0;
            b = 8'hCC;
            op = 3'(i);
            tick();
            in_valid = 1'b0;
            a = 'x;
            b = 'x;
            op = 'x;
            total++;
            if (out_valid !== 1'b0) begin
                bad++;
                $display("FAIL op%0d_early: out_valid=%b required 0 one edge after accept", i, out_valid);
            end
            tick();
            total++;
            if (out_valid !== 1'b1 || y !== exp_y[i]) begin
                bad++;
                $display("FAIL op%0d_result: out_valid=%b y=%h required 1 %h", i, out_valid, y, exp_y[i]);
            end
        end
    endtask

    task automatic test_flags();
        logic [2:0] ops [2] = '{3'd0, 3'd1};
        logic [7:0] ey [2] = '{8'h00, 8'hFF};
        logic       ez [2] = '{1'b1, 1'b0};
        logic       eo [2] = '{1'b0, 1'b1};
        reset_dut();
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            a = 8'h0F;
            b = 8'hF0;
            op = ops[i];
            tick();
            in_valid = 1'b0;
            tick();
            total++;
            if (out_valid !== 1'b1 || y !== ey[i] || zero !== ez[i] || ones !== eo[i]) begin
                bad++;
                $display("FAIL flags%0d: valid=%b y=%h zero=%b ones=%b required 1 %h %b %b",
                         i, out_valid, y, zero, ones, ey[i], ez[i], eo[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int sent = 0;
        int got = 0;
        int cyc = 0;
        int sent_at_block = -1;
        logic held = 1'b0;
        logic [7:0] hy = '0;
        logic hz = 1'b0;
        logic ho = 1'b0;
        exp_t e;
        reset_dut();
        while (got < 4 && cyc < 60) begin
            if (held) begin
                total++;
                if (out_valid !== 1'b1 || y !== hy || zero !== hz || ones !== ho) begin
                    bad++;
                    $display("FAIL bp_hold: valid=%b y=%h zero=%b ones=%b required 1 %h %b %b",
                             out_valid, y, zero, ones, hy, hz, ho);
                end
            end
            out_ready = !(cyc >= 2 && cyc < 8);
            in_valid = (sent < 4);
            a = 8'($urandom);
            b = 8'($urandom);
            op = 3'($urandom_range(0, 7));
            #1;
            if (in_valid && !in_ready && sent_at_block < 0) sent_at_block = sent;
            if (in_valid && in_ready) begin
                exp_q.push_back(model(op, a, b));
                sent++;
            end
            held = out_valid && !out_ready;
            hy = y;
            hz = zero;
            ho = ones;
            if (out_valid && out_ready) begin
                got++;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL bp_extra: y=%h required no output", y);
                end else begin
                    e = exp_q.pop_front();
                    if (y !== e.y || zero !== e.zero || ones !== e.ones) begin
                        bad++;
                        $display("FAIL bp_data: y=%h zero=%b ones=%b required %h %b %b",
                                 y, zero, ones, e.y, e.zero, e.ones);
                    end
                end
            end
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        total++;
        if (sent_at_block !== 2) begin
            bad++;
            $display("FAIL bp_block: in_ready first low after %0d beats, required 2", sent_at_block);
        end
        total++;
        if (got !== 4 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL bp_count: results=%0d pending=%0d required 4 0", got, exp_q.size());
        end
        total++;
        if (op_count !== 16'd4) begin
            bad++;
            $display("FAIL bp_op_count: op_count=%0d required 4", op_count);
        end
    endtask

    task automatic test_back_to_back();
        int sent = 0;
        int got = 0;
        int first = -1;
        int last = -1;
        exp_t e;
        reset_dut();
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 40 && got < 16; cyc++) begin
            in_valid = (sent < 16);
            a = 8'($urandom);
            b = 8'($urandom);
            op = 3'($urandom_range(0, 7));
            #1;
            if (in_valid) begin
                total++;
                if (in_ready !== 1'b1) begin
                    bad++;
                    $display("FAIL b2b_in_ready: cycle %0d in_ready=%b required 1", cyc, in_ready);
                end else begin
                    exp_q.push_back(model(op, a, b));
                    sent++;
                end
            end
            if (out_valid && out_ready) begin
                if (first < 0) first = cyc;
                last = cyc;
                got++;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL b2b_extra: y=%h required no output", y);
                end else begin
                    e = exp_q.pop_front();
                    if (y !== e.y || zero !== e.zero || ones !== e.ones) begin
                        bad++;
                        $display("FAIL b2b_data: y=%h zero=%b ones=%b required %h %b %b",
                                 y, zero, ones, e.y, e.zero, e.ones);
                    end
                end
            end
            tick();
        end
        in_valid = 1'b0;
        total++;
        if (got !== 16 || (last - first) !== 15) begin
            bad++;
            $display("FAIL b2b_stream: results=%0d span=%0d required 16 15", got, last - first);
        end
        total++;
        if (op_count !== 16'd16) begin
            bad++;
            $display("FAIL b2b_op_count: op_count=%0d required 16", op_count);
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            a = 8'($urandom) | 8'h01;
            b = 8'($urandom);
            op = 3'd7;
            tick();
        end
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (out_valid !== 1'b0 || y !== 8'h00 || op_count !== 16'd0) begin
            bad++;
            $display("FAIL mid_reset: out_valid=%b y=%h op_count=%0d required 0 00 0", out_valid, y, op_count);
        end
        @(posedge clk);
        #3;
        rst = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 6; i++) begin
            tick();
            total++;
            if (out_valid !== 1'b0) begin
                bad++;
                $display("FAIL mid_stale: cycle %0d out_valid=%b required 0", i, out_valid);
            end
        end
    endtask

    task automatic test_saturation();
        int sent = 0;
        int n = 0;
        int want;
        exp_t e;
        reset_dut();
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 30 && n < 10; cyc++) begin
            in_valid = (sent < 10);
            a = 8'($urandom);
            b = 8'($urandom);
            op = 3'($urandom_range(0, 7));
            #1;
            if (in_valid && in_ready_s) begin
                exp_q.push_back(model(op, a, b));
                sent++;
            end
            if (out_valid_s && out_ready) begin
                n++;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL sat_extra: y=%h required no output", y_s);
                end else begin
                    e = exp_q.pop_front();
                    if (y_s !== e.y || zero_s !== e.zero || ones_s !== e.ones) begin
                        bad++;
                        $display("FAIL sat_data: y=%h zero=%b ones=%b required %h %b %b",
                                 y_s, zero_s, ones_s, e.y, e.zero, e.ones);
                    end
                end
            end
            tick();
            want = (n > 7) ? 7 : n;
            total++;
            if (op_count_s !== 3'(want)) begin
                bad++;
                $display("FAIL sat_count: op_count=%0d required %0d", op_count_s, want);
            end
        end
        in_valid = 1'b0;
        total++;
        if (n !== 10 || op_count_s !== 3'd7) begin
            bad++;
            $display("FAIL sat_final: results=%0d op_count=%0d required 10 7", n, op_count_s);
        end
    endtask

    initial begin
        test_reset();
        test_all_ops();
        test_flags();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
